rec_mvd_rd_ctrl: RTL

REC_MVD_RD_CTRL -- requirements
Module: rec_mvd_rd_ctrl

---
 rtl/rec_mvd_rd_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rec_mvd_rd_ctrl.sv
// Read-out controller for the mvd buffer: streams entries 0..num-1 from the rd_2 port
// through a 2-entry skid FIFO to a valid/ready consumer.
`ifndef MVD_WIDTH
`define MVD_WIDTH 10
`endif

module rec_mvd_rd_ctrl #(
  parameter int DAT_WID = 2*`MVD_WIDTH+1,
  parameter int ADR_WID = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [6:0]         num_i,
  output logic               rd_ena_o,
  output logic [ADR_WID-1:0] rd_adr_o,
  input  logic [DAT_WID-1:0] rd_dat_i,
  output logic               mvd_val_o,
  output logic [DAT_WID-1:0] mvd_dat_o,
  input  logic               mvd_rdy_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [6:0]         num_q, num_d;
  logic [6:0]         rd_cnt_q, rd_cnt_d;
  logic [6:0]         out_cnt_q, out_cnt_d;
  logic               done_q, done_d;
  logic               infl_q;
  logic [ADR_WID-1:0] adr_q;
  logic [DAT_WID-1:0] fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         fifo_cnt_q;

  logic accept, pop, push, room, issue, last_pop;

  assign accept = (state_q == IDLE) && start_i && (num_i != 7'd0);
  assign pop    = mvd_val_o && mvd_rdy_i;
  assign push   = infl_q;

  // A read is only launched if its return is guaranteed a FIFO slot.
  assign room  = ({1'b0, fifo_cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign issue = rstn && room && (accept || ((state_q == RUN) && (rd_cnt_q < num_q)));

  assign last_pop = pop && (state_q != IDLE) && (out_cnt_q == num_q - 7'd1);

  // The first read goes out combinationally in the start cycle to meet the 2-cycle latency.
  assign rd_ena_o  = issue;
  assign rd_adr_o  = issue ? (accept ? '0 : rd_cnt_q[ADR_WID-1:0]) : adr_q;
  assign mvd_val_o = (fifo_cnt_q != 2'd0);
  assign mvd_dat_o = fifo_q[rd_ptr_q];
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_i == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            num_d     = num_i;
            rd_cnt_d  = {6'd0, issue};
            out_cnt_d = 7'd0;
          end
        end
      end
      RUN, FLUSH: begin
        if (issue) rd_cnt_d = rd_cnt_q + 7'd1;
        if (pop)   out_cnt_d = out_cnt_q + 7'd1;
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if ((state_q == RUN) && (rd_cnt_d == num_q)) begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      num_q     <= 7'd0;
      rd_cnt_q  <= 7'd0;
      out_cnt_q <= 7'd0;
      done_q    <= 1'b0;
      infl_q    <= 1'b0;
      adr_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      infl_q    <= issue;
      adr_q     <= rd_adr_o;
    end
  end

  // Returned word lands in the FIFO the cycle after its read enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_dat_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
